// File: rtl/regfile_console.sv
// Register-file debug console: debounced byte-lane writes into a DATA_W x 2**ADDR_W
// bank, registered read-back, and a DIGITS-nibble display window chosen manually or
// by a free-running auto-scroll.
//
// Write interface: there is no ready/busy back-pressure. Each debounced press
// commits exactly one write on the edge that enters HELD, and wr_ack is high for
// the single cycle that follows that edge. Writes to reg 0 and to out-of-range
// lanes still acknowledge but leave the bank untouched.
module regfile_console #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 5,
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCROLL_DIV      = 2**24,
    localparam int NLANE  = DATA_W / 8,
    localparam int NWIN   = DATA_W / (4 * DIGITS),
    localparam int LANE_W = (NLANE > 1) ? $clog2(NLANE) : 1,
    localparam int WIN_W  = (NWIN > 1) ? $clog2(NWIN) : 1
) (
    input  logic                  cu_clk,
    input  logic                  btn_reset,
    input  logic                  btn_write,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [LANE_W-1:0]     wr_lane,
    input  logic [7:0]            wr_byte,
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic [WIN_W-1:0]      win_sel,
    input  logic                  auto_scroll,
    output logic [DATA_W-1:0]     rd_data,
    output logic [4*DIGITS-1:0]   disp_value,
    output logic [WIN_W-1:0]      disp_win,
    output logic                  wr_ack
);

    localparam int DIGW  = 4 * DIGITS;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int SC_W  = $clog2(SCROLL_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCROLL_DIV - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(NWIN - 1);

    // Debounce state is kept as a named enum so checkers can bind to it directly.
    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic                fire;
    logic [1:0]          sync;
    logic                sb;
    logic [DATA_W-1:0]   regs [2**ADDR_W];
    logic [DATA_W-1:0]   merged;
    logic                lane_ok;
    logic                wr_en;
    logic [DATA_W-1:0]   rd_next;
    logic [SC_W-1:0]     scroll_cnt;

    assign sb = sync[1];

    // Two-flop synchroniser for the raw pushbutton.
    always_ff @(posedge cu_clk or negedge btn_reset) begin
        if (!btn_reset) sync <= 2'b00;
        else            sync <= {sync[0], btn_write};
    end

    // Debounce FSM state and shared stability counter.
    always_ff @(posedge cu_clk or negedge btn_reset) begin
        if (!btn_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: the press must be stable for DEBOUNCE_CYCLES before firing,
    // and the release must be equally stable before another press is recognised.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (sb) begin
                    state_next = PRESS;
                    cnt_next   = '0;
                end
            end
            PRESS: begin
                if (!sb) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = HELD;
                    fire       = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!sb) begin
                    state_next = RELEASE;
                    cnt_next   = '0;
                end
            end
            RELEASE: begin
                if (sb) begin
                    state_next = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Merge the new byte into the addressed register; lanes past the top are ignored.
    always_comb begin
        merged  = regs[wr_addr];
        lane_ok = 1'b0;
        for (int l = 0; l < NLANE; l++) begin
            if (wr_lane == LANE_W'(l)) begin
                merged[8*l +: 8] = wr_byte;
                lane_ok          = 1'b1;
            end
        end
    end

    assign wr_en = fire && lane_ok && (wr_addr != '0);

    // Read value forwards a same-edge write so rd_data shows post-write content.
    always_comb begin
        if (rd_addr == '0)                   rd_next = '0;
        else if (wr_en && wr_addr == rd_addr) rd_next = merged;
        else                                  rd_next = regs[rd_addr];
    end

    // Register bank; reg 0 is never written so it stays zero.
    always_ff @(posedge cu_clk or negedge btn_reset) begin
        if (!btn_reset) begin
            for (int r = 0; r < 2**ADDR_W; r++) regs[r] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= merged;
        end
    end

    // Registered read data and one-cycle write acknowledge.
    always_ff @(posedge cu_clk or negedge btn_reset) begin
        if (!btn_reset) begin
            rd_data <= '0;
            wr_ack  <= 1'b0;
        end else begin
            rd_data <= rd_next;
            wr_ack  <= fire;
        end
    end

    // Window select: clamped manual choice, or prescaled auto-scroll from the current window.
    always_ff @(posedge cu_clk or negedge btn_reset) begin
        if (!btn_reset) begin
            disp_win   <= '0;
            scroll_cnt <= '0;
        end else if (!auto_scroll) begin
            scroll_cnt <= '0;
            disp_win   <= (win_sel > WIN_LAST) ? WIN_LAST : win_sel;
        end else if (scroll_cnt == SC_LAST) begin
            scroll_cnt <= '0;
            disp_win   <= (disp_win == WIN_LAST) ? '0 : disp_win + 1'b1;
        end else begin
            scroll_cnt <= scroll_cnt + 1'b1;
        end
    end

    // Window extraction for the seven-segment driver.
    always_comb begin
        disp_value = '0;
        for (int w = 0; w < NWIN; w++) begin
            if (disp_win == WIN_W'(w)) disp_value = rd_data[DIGW*w +: DIGW];
        end
    end

endmodule
